// File: rtl/hello_pkg.sv
// Shared types and constants for the HELLO scroller.
// This package holds the character codes, segment patterns and FSM states.
package hello_pkg;
  localparam int NUM_CHARS = 5;

  typedef logic [2:0] char_t;
  typedef logic [6:0] seg_t;

  localparam char_t CH_H     = 3'b000;
  localparam char_t CH_E     = 3'b001;
  localparam char_t CH_L     = 3'b010;
  localparam char_t CH_O     = 3'b011;
  localparam char_t CH_BLANK = 3'b111;

  // Segment patterns are listed a..g from MSB to LSB and are active-low.
  localparam seg_t SEG_H     = 7'b1001000;
  localparam seg_t SEG_E     = 7'b0110000;
  localparam seg_t SEG_L     = 7'b1110001;
  localparam seg_t SEG_O     = 7'b0000001;
  localparam seg_t SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_t;
endpackage

// File: rtl/hello_scroller_char_to_seg.sv
// Combinational decoder from a character code to an active-low a..g segment pattern.
module char_to_seg
  import hello_pkg::*;
(
  input  logic [2:0] code,
  output logic [0:6] seg
);
  always_comb begin
    seg = SEG_BLANK;
    case (code)
      CH_H:    seg = SEG_H;
      CH_E:    seg = SEG_E;
      CH_L:    seg = SEG_L;
      CH_O:    seg = SEG_O;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/hello_scroller.sv
// Loads a five-character message over valid/ready handshaking.
// It then rotates the message across HEX4..HEX0 once every TICK_DIV clock cycles.
module hello_scroller
  import hello_pkg::*;
#(
  parameter int TICK_DIV = 25_000_000
) (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic       load_valid,
  input  logic [2:0] load_char,
  output logic       load_ready,
  input  logic       run,
  input  logic       dir,
  output logic       step,
  output logic [2:0] Char4,
  output logic [2:0] Char3,
  output logic [2:0] Char2,
  output logic [2:0] Char1,
  output logic [2:0] Char0,
  output logic [0:6] HEX4,
  output logic [0:6] HEX3,
  output logic [0:6] HEX2,
  output logic [0:6] HEX1,
  output logic [0:6] HEX0
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);
  localparam logic [NUM_CHARS-1:0][2:0] HELLO = {CH_H, CH_E, CH_L, CH_L, CH_O};

  state_t                      state_q, state_d;
  logic [2:0]                  wr_idx_q, wr_idx_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic [NUM_CHARS-1:0][2:0]   msg_q, msg_d;
  logic                        step_q, step_d;
  logic                        accept;
  logic [NUM_CHARS-1:0][0:6]   seg;

  assign load_ready = (state_q != SCROLL);
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_d  = state_q;
    wr_idx_d = wr_idx_q;
    cnt_d    = cnt_q;
    msg_d    = msg_q;
    step_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // If a character is accepted in the same cycle that run is high, the load takes priority.
        if (accept) begin
          msg_d[NUM_CHARS-1] = load_char;
          wr_idx_d           = 3'd3;
          state_d            = LOAD;
        end else if (run) begin
          cnt_d   = '0;
          state_d = SCROLL;
        end
      end
      LOAD: begin
        if (accept) begin
          msg_d[wr_idx_q] = load_char;
          if (wr_idx_q == 3'd0) begin
            wr_idx_d = 3'd4;
            cnt_d    = '0;
            state_d  = run ? SCROLL : IDLE;
          end else begin
            wr_idx_d = wr_idx_q - 3'd1;
          end
        end
      end
      SCROLL: begin
        if (cnt_q == TC) begin
          cnt_d  = '0;
          step_d = 1'b1;
          msg_d  = dir ? {msg_q[0], msg_q[NUM_CHARS-1:1]}
                       : {msg_q[NUM_CHARS-2:0], msg_q[NUM_CHARS-1]};
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // If run drops on the terminal-count cycle, the rotation above still takes effect.
        if (!run) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      wr_idx_q <= 3'd4;
      cnt_q    <= '0;
      msg_q    <= HELLO;
      step_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      cnt_q    <= cnt_d;
      msg_q    <= msg_d;
      step_q   <= step_d;
    end
  end

  assign step  = step_q;
  assign Char4 = msg_q[4];
  assign Char3 = msg_q[3];
  assign Char2 = msg_q[2];
  assign Char1 = msg_q[1];
  assign Char0 = msg_q[0];

  for (genvar i = 0; i < NUM_CHARS; i++) begin : g_seg
    char_to_seg u_seg (.code(msg_q[i]), .seg(seg[i]));
  end

  assign HEX4 = seg[4];
  assign HEX3 = seg[3];
  assign HEX2 = seg[2];
  assign HEX1 = seg[1];
  assign HEX0 = seg[0];
endmodule
